// File: rtl/carfield_pkg.sv
// Shared Carfield definitions: APB peripheral map, peripheral index enum and
// the APB arbiter FSM state encoding.
package carfield_pkg;

  localparam int unsigned NumApbMst   = 5;
  localparam int unsigned ApbIdxWidth = $clog2(NumApbMst);

  typedef enum logic [ApbIdxWidth-1:0] {
    ApbSysTimer = 3'd0,
    ApbAdvTimer = 3'd1,
    ApbWatchdog = 3'd2,
    ApbCan      = 3'd3,
    ApbHyperbus = 3'd4
  } apb_periph_e;

  // Packed arrays list the highest index first
  localparam logic [NumApbMst-1:0][31:0] ApbBase = {
    32'h2000_9000, 32'h2000_1000, 32'h2000_7000, 32'h2000_5000, 32'h2000_4000
  };
  localparam logic [NumApbMst-1:0][31:0] ApbSize = {NumApbMst{32'h0000_1000}};

  function automatic logic [NumApbMst-1:0][31:0] calcApbEnd();
    logic [NumApbMst-1:0][31:0] e;
    for (int unsigned k = 0; k < NumApbMst; k++) e[k] = ApbBase[k] + ApbSize[k];
    return e;
  endfunction

  localparam logic [NumApbMst-1:0][31:0] ApbEnd = calcApbEnd();

  typedef enum logic [2:0] {
    ArbIdle   = 3'd0,
    ArbSetup  = 3'd1,
    ArbAccess = 3'd2,
    ArbResp   = 3'd3,
    ArbErr    = 3'd4
  } apb_arb_state_e;

endpackage

// File: rtl/carfield_apb_addr_decode.sv
// Combinational APB address decoder over the Carfield peripheral map;
// the lowest matching index wins when ranges overlap.
module carfield_apb_addr_decode
  import carfield_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 hit_c,
  output apb_periph_e          idx_c
);

  // Scan downward so the lowest hitting index is written last
  always_comb begin
    hit_c = 1'b0;
    idx_c = ApbSysTimer;
    for (int k = int'(NumApbMst) - 1; k >= 0; k--) begin
      if (addr_i >= AddrWidth'(ApbBase[k]) && addr_i < AddrWidth'(ApbEnd[k])) begin
        hit_c = 1'b1;
        idx_c = apb_periph_e'(ApbIdxWidth'(k));
      end
    end
  end

endmodule

// File: rtl/carfield_apb_arbiter.sv
// Round-robin APB arbiter/sequencer for the Carfield peripheral bus.
// Optional ACCESS timeout enabled by `define CARFIELD_APB_ARB_TIMEOUT_EN.
module carfield_apb_arbiter
  import carfield_pkg::*;
#(
  parameter int unsigned NumReq        = 3,
  parameter int unsigned NumApbSlv     = NumApbMst,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_psel_i,
  input  logic [NumReq-1:0]                     req_penable_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      req_paddr_i,
  input  logic [NumReq-1:0]                     req_pwrite_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      req_pwdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    req_pstrb_i,
  output logic [NumReq-1:0]                     req_pready_o,
  output logic [NumReq-1:0][DataWidth-1:0]      req_prdata_o,
  output logic [NumReq-1:0]                     req_pslverr_o,
  output logic [NumApbSlv-1:0]                  apb_psel_o,
  output logic                                  apb_penable_o,
  output logic [AddrWidth-1:0]                  apb_paddr_o,
  output logic                                  apb_pwrite_o,
  output logic [DataWidth-1:0]                  apb_pwdata_o,
  output logic [DataWidth/8-1:0]                apb_pstrb_o,
  input  logic [NumApbSlv-1:0]                  apb_pready_i,
  input  logic [NumApbSlv-1:0][DataWidth-1:0]   apb_prdata_i,
  input  logic [NumApbSlv-1:0]                  apb_pslverr_i
);

  localparam int unsigned ReqW = $clog2(NumReq);

  apb_arb_state_e        state, stateNext;
  logic [ReqW-1:0]       lastQ, grantQ, arbIdx;
  logic                  arbValid;
  apb_periph_e           idxQ, decIdx;
  logic                  decHit;
  logic [DataWidth-1:0]  rdataQ;
  logic                  errQ;
  logic                  toExpire;
  logic                  unusedOk;

  // penable is ignored for arbitration; TimeoutCycles only matters with the timeout build
  assign unusedOk = ^{req_penable_i, 32'(TimeoutCycles)};

  // Round-robin search starting just after the last grantee
  always_comb begin
    arbValid = 1'b0;
    arbIdx   = lastQ;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      if (!arbValid && req_psel_i[ReqW'((32'(lastQ) + i) % NumReq)]) begin
        arbValid = 1'b1;
        arbIdx   = ReqW'((32'(lastQ) + i) % NumReq);
      end
    end
  end

  carfield_apb_addr_decode #(
    .AddrWidth (AddrWidth)
  ) uDecode (
    .addr_i (req_paddr_i[arbIdx]),
    .hit_c  (decHit),
    .idx_c  (decIdx)
  );

`ifdef CARFIELD_APB_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles) + 1;
  logic [ToW-1:0] toCnt;

  assign toExpire = (ToW'(toCnt + 1'b1) == ToW'(TimeoutCycles));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      toCnt <= '0;
    end else if (state == ArbSetup) begin
      toCnt <= '0;
    end else if (state == ArbAccess && !apb_pready_i[idxQ]) begin
      toCnt <= ToW'(toCnt + 1'b1);
    end
  end
`else
  assign toExpire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ArbIdle;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ArbIdle:   if (arbValid) stateNext = decHit ? ArbSetup : ArbErr;
      ArbSetup:  stateNext = ArbAccess;
      ArbAccess: if (apb_pready_i[idxQ] || toExpire) stateNext = ArbResp;
      ArbResp:   stateNext = ArbIdle;
      ArbErr:    stateNext = ArbIdle;
      default:   stateNext = ArbIdle;
    endcase
  end

  // Grant capture and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lastQ        <= ReqW'(NumReq - 1);
      grantQ       <= '0;
      idxQ         <= ApbSysTimer;
      apb_paddr_o  <= '0;
      apb_pwrite_o <= 1'b0;
      apb_pwdata_o <= '0;
      apb_pstrb_o  <= '0;
      rdataQ       <= '0;
      errQ         <= 1'b0;
    end else begin
      if (state == ArbIdle && arbValid) begin
        grantQ       <= arbIdx;
        lastQ        <= arbIdx;
        idxQ         <= decIdx;
        apb_paddr_o  <= req_paddr_i[arbIdx];
        apb_pwrite_o <= req_pwrite_i[arbIdx];
        apb_pwdata_o <= req_pwdata_i[arbIdx];
        apb_pstrb_o  <= req_pstrb_i[arbIdx];
      end
      if (state == ArbAccess) begin
        if (apb_pready_i[idxQ]) begin
          rdataQ <= apb_prdata_i[idxQ];
          errQ   <= apb_pslverr_i[idxQ];
        end else if (toExpire) begin
          rdataQ <= '0;
          errQ   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    apb_psel_o    = '0;
    apb_penable_o = 1'b0;
    req_pready_o  = '0;
    req_prdata_o  = '0;
    req_pslverr_o = '0;
    case (state)
      ArbSetup: apb_psel_o[idxQ] = 1'b1;
      ArbAccess: begin
        apb_psel_o[idxQ] = 1'b1;
        apb_penable_o    = 1'b1;
      end
      ArbResp: begin
        req_pready_o[grantQ]  = 1'b1;
        req_prdata_o[grantQ]  = rdataQ;
        req_pslverr_o[grantQ] = errQ;
      end
      ArbErr: begin
        req_pready_o[grantQ]  = 1'b1;
        req_pslverr_o[grantQ] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
